// File: rtl/msp_ctrl_pkg.sv
// rtl/msp_ctrl_pkg.sv - shared constants and FSM state type for the MSP-style decode controller
package msp_ctrl_pkg;

    // ALU operation selects
    localparam logic [4:0] SEL_MOV  = 5'b00000;
    localparam logic [4:0] SEL_ADD  = 5'b00001;
    localparam logic [4:0] SEL_ADDC = 5'b00010;
    localparam logic [4:0] SEL_SUB  = 5'b00011;
    localparam logic [4:0] SEL_SUBC = 5'b00100;
    localparam logic [4:0] SEL_CMP  = 5'b00101;
    localparam logic [4:0] SEL_DADD = 5'b00110;
    localparam logic [4:0] SEL_BIT  = 5'b00111;
    localparam logic [4:0] SEL_BIC  = 5'b01000;
    localparam logic [4:0] SEL_BIS  = 5'b01001;
    localparam logic [4:0] SEL_XOR  = 5'b01010;
    localparam logic [4:0] SEL_AND  = 5'b01011;
    localparam logic [4:0] SEL_ZERO = 5'b01100;
    localparam logic [4:0] SEL_RRC  = 5'b10000;

    // Format I opcodes (instr[15:12])
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_SUBC = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_DADD = 4'hA;
    localparam logic [3:0] OP_BIT  = 4'hB;
    localparam logic [3:0] OP_BIC  = 4'hC;
    localparam logic [3:0] OP_BIS  = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_AND  = 4'hF;

    // Format II prefix (instr[15:10]) and RRC sub-opcode (instr[9:7])
    localparam logic [5:0] FMT2_PREFIX = 6'b000100;
    localparam logic [2:0] FMT2_RRC    = 3'b000;

    // Status flag bit positions
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_ILLEGAL
    } state_t;

endpackage

// File: rtl/msp_op_decode.sv
// rtl/msp_op_decode.sv - combinational instruction field decode; RRC decode present only with DECODE_FMT2_EN
module msp_op_decode
    import msp_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [4:0]  sel,
    output logic [3:0]  rs,
    output logic [3:0]  rd,
    output logic        byte_op,
    output logic        writes_rd,
    output logic        updates_sr,
    output logic        illegal
);

    // Map the opcode to an ALU select and its write-back/flag side effects
    always_comb begin
        sel        = SEL_ZERO;
        rs         = instr[11:8];
        rd         = instr[3:0];
        byte_op    = instr[6];
        writes_rd  = 1'b0;
        updates_sr = 1'b0;
        illegal    = 1'b1;
        if (instr[15:12] >= OP_MOV) begin
            writes_rd  = 1'b1;
            updates_sr = 1'b1;
            // only register-direct source and destination are supported
            illegal    = (instr[5:4] != 2'b00) || instr[7];
            case (instr[15:12])
                OP_MOV:  begin sel = SEL_MOV; updates_sr = 1'b0; end
                OP_ADD:  sel = SEL_ADD;
                OP_ADDC: sel = SEL_ADDC;
                OP_SUBC: sel = SEL_SUBC;
                OP_SUB:  sel = SEL_SUB;
                OP_CMP:  begin sel = SEL_CMP; writes_rd = 1'b0; end
                OP_DADD: sel = SEL_DADD;
                OP_BIT:  begin sel = SEL_BIT; writes_rd = 1'b0; end
                OP_BIC:  begin sel = SEL_BIC; updates_sr = 1'b0; end
                OP_BIS:  begin sel = SEL_BIS; updates_sr = 1'b0; end
                OP_XOR:  sel = SEL_XOR;
                OP_AND:  sel = SEL_AND;
                default: illegal = 1'b1;
            endcase
        end
`ifdef DECODE_FMT2_EN
        else if (instr[15:10] == FMT2_PREFIX) begin
            if ((instr[9:7] == FMT2_RRC) && (instr[5:4] == 2'b00)) begin
                sel        = SEL_RRC;
                rs         = instr[3:0];
                writes_rd  = 1'b1;
                updates_sr = 1'b1;
                illegal    = 1'b0;
            end
        end
`endif
    end

endmodule

// File: rtl/msp_decode_ctrl.sv
// rtl/msp_decode_ctrl.sv - decode/exec/write-back sequencer for the 16-bit ALU; option macro DECODE_FMT2_EN
module msp_decode_ctrl
    import msp_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 5,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic              instr_ready,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rd_addr,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rf_we,
    output logic [1:0]        rf_be,
    output logic [3:0]        wb_addr,
    output logic [FLAG_W-1:0] sr,
    output logic              illegal
);

    state_t            state;
    logic [DATA_W-1:0] instr_q;
    logic              byte_q;
    logic              writes_q;
    logic              upd_q;

    logic [4:0] dec_sel;
    logic [3:0] dec_rs;
    logic [3:0] dec_rd;
    logic       dec_byte;
    logic       dec_writes;
    logic       dec_upd;
    logic       dec_illegal;

    msp_op_decode u_decode (
        .instr      (instr_q),
        .sel        (dec_sel),
        .rs         (dec_rs),
        .rd         (dec_rd),
        .byte_op    (dec_byte),
        .writes_rd  (dec_writes),
        .updates_sr (dec_upd),
        .illegal    (dec_illegal)
    );

    // Sequencer: all outputs are registered so they change only on state transitions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            byte_q      <= 1'b0;
            writes_q    <= 1'b0;
            upd_q       <= 1'b0;
            instr_ready <= 1'b1;
            alu_sel     <= SEL_ZERO;
            rs_addr     <= '0;
            rd_addr     <= '0;
            rf_we       <= 1'b0;
            rf_be       <= 2'b00;
            wb_addr     <= '0;
            sr          <= '0;
            illegal     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                        state   <= ST_ILLEGAL;
                    end else begin
                        alu_sel  <= dec_sel;
                        rs_addr  <= dec_rs;
                        rd_addr  <= dec_rd;
                        byte_q   <= dec_byte;
                        writes_q <= dec_writes;
                        upd_q    <= dec_upd;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // flags are valid at the end of the execute cycle
                    if (upd_q) begin
                        sr <= alu_flags;
                    end
                    rf_we <= writes_q;
                    if (writes_q) begin
                        wb_addr <= rd_addr;
                    end
                    rf_be <= byte_q ? 2'b01 : 2'b11;
                    state <= ST_WB;
                end
                ST_WB: begin
                    rf_we       <= 1'b0;
                    alu_sel     <= SEL_ZERO;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_ILLEGAL: begin
                    illegal     <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    alu_sel     <= SEL_ZERO;
                    rf_we       <= 1'b0;
                    illegal     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msp_decode_ctrl.sv
// tb/tb_msp_decode_ctrl.sv - directed vector bench for msp_decode_ctrl
module tb_msp_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [4:0]  alu_sel;
    logic [3:0]  rs_addr;
    logic [3:0]  rd_addr;
    logic [3:0]  alu_flags;
    logic        rf_we;
    logic [1:0]  rf_be;
    logic [3:0]  wb_addr;
    logic [3:0]  sr;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    logic [3:0] sr_model;

    localparam logic [4:0] ZERO_SEL = 5'b01100;
    localparam logic [3:0] IDLE_FLAGS = 4'b1111;

    always #5 clk = ~clk;

    msp_decode_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_sel     (alu_sel),
        .rs_addr     (rs_addr),
        .rd_addr     (rd_addr),
        .alu_flags   (alu_flags),
        .rf_we       (rf_we),
        .rf_be       (rf_be),
        .wb_addr     (wb_addr),
        .sr          (sr),
        .illegal     (illegal)
    );

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  flags;
        logic        ill;
        logic [4:0]  sel;
        logic [3:0]  rs;
        logic [3:0]  rd;
        logic        we;
        logic [1:0]  be;
        logic        upd;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d_%04h", idx, v.ins);
        instr_valid = 1'b1;
        instr       = v.ins;
        check({tag, "_ready0"}, 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        check({tag, "_dec_ready"}, 32'(instr_ready), 32'd0);
        check({tag, "_dec_sel"}, 32'(alu_sel), 32'(ZERO_SEL));
        step();
        if (v.ill) begin
            check({tag, "_ill_pulse"}, 32'(illegal), 32'd1);
            check({tag, "_ill_we"}, 32'(rf_we), 32'd0);
            step();
            check({tag, "_ill_ready"}, 32'(instr_ready), 32'd1);
            check({tag, "_ill_clear"}, 32'(illegal), 32'd0);
            check({tag, "_ill_sr"}, 32'(sr), 32'(sr_model));
        end else begin
            check({tag, "_ex_sel"}, 32'(alu_sel), 32'(v.sel));
            check({tag, "_ex_rs"}, 32'(rs_addr), 32'(v.rs));
            check({tag, "_ex_rd"}, 32'(rd_addr), 32'(v.rd));
            check({tag, "_ex_ill"}, 32'(illegal), 32'd0);
            alu_flags = v.flags;
            step();
            alu_flags = IDLE_FLAGS;
            if (v.upd) sr_model = v.flags;
            check({tag, "_wb_we"}, 32'(rf_we), 32'(v.we));
            if (v.we) begin
                check({tag, "_wb_addr"}, 32'(wb_addr), 32'(v.rd));
                check({tag, "_wb_be"}, 32'(rf_be), 32'(v.be));
            end
            check({tag, "_wb_ready"}, 32'(instr_ready), 32'd0);
            check({tag, "_wb_sr"}, 32'(sr), 32'(sr_model));
            step();
            check({tag, "_idle_ready"}, 32'(instr_ready), 32'd1);
            check({tag, "_idle_we"}, 32'(rf_we), 32'd0);
            check({tag, "_idle_sel"}, 32'(alu_sel), 32'(ZERO_SEL));
        end
    endtask

    initial begin
        logic [11:0] acc_mask;
        int          we_cnt;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        alu_flags   = IDLE_FLAGS;
        sr_model    = 4'b0000;

        //       instr     flags    ill   sel       rs    rd    we    be     upd
        vq.push_back('{16'h5405, 4'b0110, 1'b0, 5'b00001, 4'h4, 4'h5, 1'b1, 2'b11, 1'b1});
        vq.push_back('{16'h9405, 4'b0100, 1'b0, 5'b00101, 4'h4, 4'h5, 1'b0, 2'b11, 1'b1});
        vq.push_back('{16'h5445, 4'b1000, 1'b0, 5'b00001, 4'h4, 4'h5, 1'b1, 2'b01, 1'b1});
        vq.push_back('{16'h4405, 4'b0001, 1'b0, 5'b00000, 4'h4, 4'h5, 1'b1, 2'b11, 1'b0});
        vq.push_back('{16'h5415, 4'b0000, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});
`ifdef DECODE_FMT2_EN
        vq.push_back('{16'h1007, 4'b0010, 1'b0, 5'b10000, 4'h7, 4'h7, 1'b1, 2'b11, 1'b1});
`else
        vq.push_back('{16'h1007, 4'b0010, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});
`endif
        vq.push_back('{16'h8A0C, 4'b1001, 1'b0, 5'b00011, 4'hA, 4'hC, 1'b1, 2'b11, 1'b1});
        vq.push_back('{16'h7103, 4'b0101, 1'b0, 5'b00100, 4'h1, 4'h3, 1'b1, 2'b11, 1'b1});
        vq.push_back('{16'hB20F, 4'b0011, 1'b0, 5'b00111, 4'h2, 4'hF, 1'b0, 2'b11, 1'b1});
        vq.push_back('{16'hC30E, 4'b1010, 1'b0, 5'b01000, 4'h3, 4'hE, 1'b1, 2'b11, 1'b0});
        vq.push_back('{16'hD40D, 4'b1100, 1'b0, 5'b01001, 4'h4, 4'hD, 1'b1, 2'b11, 1'b0});
        vq.push_back('{16'hE50C, 4'b1100, 1'b0, 5'b01010, 4'h5, 4'hC, 1'b1, 2'b11, 1'b1});
        vq.push_back('{16'hF64B, 4'b0111, 1'b0, 5'b01011, 4'h6, 4'hB, 1'b1, 2'b01, 1'b1});
        vq.push_back('{16'hA701, 4'b1011, 1'b0, 5'b00110, 4'h7, 4'h1, 1'b1, 2'b11, 1'b1});
        vq.push_back('{16'h6802, 4'b1101, 1'b0, 5'b00010, 4'h8, 4'h2, 1'b1, 2'b11, 1'b1});
        vq.push_back('{16'h5485, 4'b0000, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});
        vq.push_back('{16'h2000, 4'b0000, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});
        vq.push_back('{16'h0000, 4'b0000, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});
        vq.push_back('{16'h1087, 4'b0000, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});
        vq.push_back('{16'h1017, 4'b0000, 1'b1, 5'b00000, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0});

        step();
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_sel", 32'(alu_sel), 32'(ZERO_SEL));
        check("rst_rs", 32'(rs_addr), 32'd0);
        check("rst_rd", 32'(rd_addr), 32'd0);
        check("rst_wb", 32'(wb_addr), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_be", 32'(rf_be), 32'd0);
        check("rst_sr", 32'(sr), 32'd0);
        check("rst_ill", 32'(illegal), 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], i);
        end

        // back-to-back stream: acceptance every 4 cycles, never while rf_we is high
        instr_valid = 1'b1;
        instr       = 16'h5405;
        alu_flags   = 4'b0111;
        acc_mask    = '0;
        we_cnt      = 0;
        for (int c = 0; c < 12; c++) begin
            if (instr_ready) acc_mask[c] = 1'b1;
            if (rf_we) we_cnt++;
            if (instr_ready && rf_we) check("b2b_ready_and_we", 32'd1, 32'd0);
            step();
        end
        instr_valid = 1'b0;
        alu_flags   = IDLE_FLAGS;
        sr_model    = 4'b0111;
        check("b2b_accept_mask", 32'(acc_mask), 32'h111);
        check("b2b_we_count", 32'(we_cnt), 32'd3);
        check("b2b_sr", 32'(sr), 32'(sr_model));
        check("b2b_idle", 32'(instr_ready), 32'd1);

        // reset during EXEC drops the instruction and clears sr
        instr_valid = 1'b1;
        instr       = 16'h5405;
        step();
        instr_valid = 1'b0;
        step();
        check("rexe_in_exec", 32'(alu_sel), 32'b00001);
        rst_n     = 1'b0;
        alu_flags = 4'b0110;
        step();
        check("rexe_we", 32'(rf_we), 32'd0);
        check("rexe_sr", 32'(sr), 32'd0);
        check("rexe_sel", 32'(alu_sel), 32'(ZERO_SEL));
        step();
        rst_n     = 1'b1;
        alu_flags = IDLE_FLAGS;
        step();
        check("rexe_ready_after", 32'(instr_ready), 32'd1);
        check("rexe_we_after", 32'(rf_we), 32'd0);
        step();
        check("rexe_we_later", 32'(rf_we), 32'd0);
        check("rexe_sr_after", 32'(sr), 32'd0);
        sr_model = 4'b0000;

        // reset and valid on the same edge: the instruction is not taken
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = 16'h5405;
        step();
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        step();
        check("rv_ready1", 32'(instr_ready), 32'd1);
        step();
        check("rv_ready2", 32'(instr_ready), 32'd1);
        check("rv_sel", 32'(alu_sel), 32'(ZERO_SEL));
        step();
        check("rv_we", 32'(rf_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
